jag_bus_arbiter: RTL and testbench

Main-bus arbiter for Tom that decides which master owns the external bus. The masters are DRAM refresh, the object processor, the GPU/DSP gateway and the blitter; the 68000 is the default owner. It sits upstream of every bus-master gateway and converts their registered bus requests (`breq`) into one-hot grants (`back`). It guarantees a single dead turnaround cycle between owners, forces refresh in at cycle boundaries, and bounds bus hogging with a tenure timer.

---
 rtl/jag_bus_arbiter.sv | 163 ++++++++++++++++
 tb/tb_jag_bus_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/jag_bus_arbiter.sv
// Main-bus arbiter: grants the external bus to refresh, object processor, GPU/DSP or blitter,
// with the 68000 as default owner, one turnaround cycle between owners and a tenure timer.
module jag_bus_arbiter #(
  parameter int unsigned HOG_LIMIT = 16
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic [3:0] breq,
  input  logic       dma_pri,
  input  logic       bus_hog,
  input  logic       cyc_active,
  input  logic       ack,
  output logic [3:0] back,
  output logic       cpu_gnt,
  output logic [2:0] owner,
  output logic       preempt
);

  typedef enum logic [1:0] {StCpu, StGrant, StTurn} state_e;

  localparam logic [4:0] HogLast  = 5'(HOG_LIMIT - 1);
  localparam logic [4:0] TimerMax = 5'd31;

  state_e     state_q, state_d;
  logic [1:0] own_q, own_d;
  logic [4:0] timer_q, timer_d;
  logic       pend_q, pend_d;
  logic [1:0] excl_q, excl_d;
  logic       excl_v_q, excl_v_d;
  logic [3:0] back_q, back_d;
  logic       cpu_gnt_q, cpu_gnt_d;
  logic [2:0] owner_q, owner_d;
  logic       preempt_q, preempt_d;

  logic       boundary;
  logic [3:0] others;
  logic       inc;
  logic       pend_cond;
  logic [3:0] cand;
  logic       win_v;
  logic [1:0] win_idx;

  assign boundary = ~cyc_active | ack;
  assign others   = breq & ~(4'b0001 << own_q);
  assign inc      = |others;

  // Timer reaching the limit (unless hogging is allowed) or a refresh request from another owner.
  assign pend_cond = (inc && (timer_q == HogLast) && !bus_hog) || (breq[0] && (own_q != 2'd0));

  always_comb begin
    cand = breq;
    if (excl_v_q) begin
      cand[excl_q] = 1'b0;
    end
    win_v   = |cand;
    win_idx = 2'd3;
    if (cand[0]) begin
      win_idx = 2'd0;
    end else if (dma_pri) begin
      if (cand[2])      win_idx = 2'd2;
      else if (cand[1]) win_idx = 2'd1;
    end else begin
      if (cand[1])      win_idx = 2'd1;
      else if (cand[2]) win_idx = 2'd2;
    end
  end

  always_comb begin
    state_d   = state_q;
    own_d     = own_q;
    timer_d   = timer_q;
    pend_d    = pend_q;
    excl_d    = excl_q;
    excl_v_d  = excl_v_q;
    preempt_d = 1'b0;

    unique case (state_q)
      StCpu: begin
        if ((|breq) && boundary) begin
          state_d  = StTurn;
          excl_v_d = 1'b0;
        end
      end
      StGrant: begin
        if (inc && (timer_q != TimerMax)) begin
          timer_d = timer_q + 5'd1;
        end
        if (pend_q && boundary) begin
          state_d  = StTurn;
          excl_d   = own_q;
          excl_v_d = 1'b1;
          pend_d   = 1'b0;
        end else if (!breq[own_q] && boundary) begin
          // A preempt condition arising on the release cycle still excludes the old owner.
          state_d  = StTurn;
          excl_d   = own_q;
          excl_v_d = pend_cond;
          pend_d   = 1'b0;
        end else if (!pend_q && pend_cond) begin
          pend_d    = 1'b1;
          preempt_d = 1'b1;
        end
      end
      StTurn: begin
        excl_v_d = 1'b0;
        timer_d  = 5'd0;
        if (win_v) begin
          state_d = StGrant;
          own_d   = win_idx;
        end else begin
          state_d = StCpu;
        end
      end
      default: begin
        state_d = StCpu;
      end
    endcase

    back_d    = 4'b0000;
    cpu_gnt_d = 1'b0;
    owner_d   = 3'd7;
    if (state_d == StGrant) begin
      back_d  = 4'b0001 << own_d;
      owner_d = {1'b0, own_d};
    end else if (state_d == StCpu) begin
      cpu_gnt_d = 1'b1;
      owner_d   = 3'd4;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= StCpu;
      own_q     <= 2'd0;
      timer_q   <= 5'd0;
      pend_q    <= 1'b0;
      excl_q    <= 2'd0;
      excl_v_q  <= 1'b0;
      back_q    <= 4'b0000;
      cpu_gnt_q <= 1'b1;
      owner_q   <= 3'd4;
      preempt_q <= 1'b0;
    end else if (clk_en) begin
      state_q   <= state_d;
      own_q     <= own_d;
      timer_q   <= timer_d;
      pend_q    <= pend_d;
      excl_q    <= excl_d;
      excl_v_q  <= excl_v_d;
      back_q    <= back_d;
      cpu_gnt_q <= cpu_gnt_d;
      owner_q   <= owner_d;
      preempt_q <= preempt_d;
    end
  end

  assign back    = back_q;
  assign cpu_gnt = cpu_gnt_q;
  assign owner   = owner_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_jag_bus_arbiter.sv
// Bench for jag_bus_arbiter: directed stimulus pushes expected outputs per enabled edge,
// a monitor pops and compares after each enabled edge.
module tb_jag_bus_arbiter;

  logic       sys_clk = 1'b0;
  logic       reset = 1'b0;
  logic       clk_en = 1'b1;
  logic [3:0] breq = 4'b0000;
  logic       dma_pri = 1'b0;
  logic       bus_hog = 1'b0;
  logic       cyc_active = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] back;
  logic       cpu_gnt;
  logic [2:0] owner;
  logic       preempt;

  typedef struct packed {
    logic [3:0] back;
    logic [2:0] owner;
    logic       cpu;
    logic       pre;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  jag_bus_arbiter #(.HOG_LIMIT(4)) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .clk_en     (clk_en),
    .breq       (breq),
    .dma_pri    (dma_pri),
    .bus_hog    (bus_hog),
    .cyc_active (cyc_active),
    .ack        (ack),
    .back       (back),
    .cpu_gnt    (cpu_gnt),
    .owner      (owner),
    .preempt    (preempt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
  endtask

  // Push the expectation for the next enabled edge, then move to the following negedge.
  task automatic tick(input logic [3:0] b, input logic [2:0] o, input logic c, input logic p);
    exp_t e;
    e.back = b; e.owner = o; e.cpu = c; e.pre = p;
    exp_q.push_back(e);
    @(negedge sys_clk);
  endtask

  task automatic t_grant(input int k, input logic p);
    logic [3:0] b;
    b = 4'b0001 << k;
    tick(b, 3'(k), 1'b0, p);
  endtask

  task automatic t_turn();
    tick(4'b0000, 3'd7, 1'b0, 1'b0);
  endtask

  task automatic t_cpu();
    tick(4'b0000, 3'd4, 1'b1, 1'b0);
  endtask

  task automatic check_out(input string tag, input logic [3:0] b, input logic [2:0] o,
                           input logic c, input logic p);
    check({tag, "_back"}, 8'(back), 8'(b));
    check({tag, "_owner"}, 8'(owner), 8'(o));
    check({tag, "_cpu_gnt"}, 8'(cpu_gnt), 8'(c));
    check({tag, "_preempt"}, 8'(preempt), 8'(p));
  endtask

  // Monitor: one expectation per enabled edge, plus the single-owner invariant.
  initial begin
    forever begin
      @(posedge sys_clk);
      if (!reset && clk_en) begin
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 8'd1, 8'd0);
        end else begin
          e = exp_q.pop_front();
          check_out("sb", e.back, e.owner, e.cpu, e.pre);
        end
        check("inv_onehot", 8'($onehot0(back)), 8'd1);
        check("inv_cpu_vs_grant", 8'(cpu_gnt && (|back)), 8'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 reset = 1'b1;
    #1 check_out("reset", 4'b0000, 3'd4, 1'b1, 1'b0);
    @(negedge sys_clk);
    reset = 1'b0;

    // Idle CPU ownership, then GPU request through one turnaround.
    t_cpu();
    breq = 4'b0100;
    t_turn();
    t_grant(2, 1'b0);
    t_grant(2, 1'b0);

    // Priority between object processor and GPU depends on dma_pri.
    breq = 4'b0000; t_turn();
    breq = 4'b0110; dma_pri = 1'b0; t_grant(1, 1'b0);
    breq = 4'b0000; t_turn();
    breq = 4'b0110; dma_pri = 1'b1; t_grant(2, 1'b0);
    breq = 4'b0000; dma_pri = 1'b0; t_turn();
    t_cpu();

    // Refresh preempts the blitter even with bus_hog, but waits for the cycle to end.
    breq = 4'b1000; t_turn();
    t_grant(3, 1'b0);
    breq = 4'b1001; cyc_active = 1'b1; ack = 1'b0; bus_hog = 1'b1;
    t_grant(3, 1'b1);
    t_grant(3, 1'b0);
    t_grant(3, 1'b0);
    ack = 1'b1; t_turn();
    ack = 1'b0; cyc_active = 1'b0; t_grant(0, 1'b0);
    breq = 4'b0000; t_turn();
    t_cpu();

    // Tenure timer: GPU preempted on the 4th waiting cycle, blitter takes over.
    bus_hog = 1'b0;
    breq = 4'b0100; t_turn();
    t_grant(2, 1'b0);
    breq = 4'b1100;
    t_grant(2, 1'b0);
    t_grant(2, 1'b0);
    t_grant(2, 1'b0);
    t_grant(2, 1'b1);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge sys_clk);
      check_out("hold_preempt", 4'b0100, 3'd2, 1'b0, 1'b1);
    end
    clk_en = 1'b1;
    t_turn();
    t_grant(3, 1'b0);

    // With bus_hog the GPU keeps the bus despite the waiting blitter.
    breq = 4'b0100; t_turn();
    t_grant(2, 1'b0);
    bus_hog = 1'b1; breq = 4'b1100;
    for (int i = 0; i < 12; i++) t_grant(2, 1'b0);

    // Disabled clock freezes outputs; async reset acts without an enabled edge.
    clk_en = 1'b0; breq = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      check_out("freeze", 4'b0100, 3'd2, 1'b0, 1'b0);
    end
    #2 reset = 1'b1;
    #1 check_out("async_reset", 4'b0000, 3'd4, 1'b1, 1'b0);
    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
